// File: rtl/ramp_word_gen.sv
// Linear ramp generator for DDS tuning words: one-shot, sawtooth or triangle sweep
// from start to end, one step per programmable dwell; state and outputs registered.
module ramp_word_gen #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 dac_clk,
   input  logic                 rstn,
   input  logic                 param_load,
   input  logic [WIDTH-1:0]     cfg_start,
   input  logic [WIDTH-1:0]     cfg_end,
   input  logic [WIDTH-1:0]     cfg_step,
   input  logic [CNT_WIDTH-1:0] cfg_pulse,
   input  logic [1:0]           cfg_mode,
   input  logic                 en,
   output logic [WIDTH-1:0]     ramp_out,
   output logic                 step_strobe,
   output logic                 sweep_done,
   output logic                 active
);

   typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN, DONE} state_t;

   state_t               state, state_n;
   logic [WIDTH-1:0]     ramp_n;
   logic [CNT_WIDTH-1:0] cnt, cnt_n;
   logic [WIDTH-1:0]     start_q, start_n, end_q, end_n, step_q, step_n;
   logic [CNT_WIDTH-1:0] pulse_q, pulse_n;
   logic [1:0]           mode_q, mode_n;
   logic                 returning, returning_n;
   logic                 at_tgt, at_tgt_n;
   logic                 strobe_n, done_n;

   logic                 saw_mode, tri_mode, flip, dir_up, ret;
   logic [WIDTH-1:0]     tgt, stepped;
   logic [WIDTH:0]       sum, diff;

   assign saw_mode = (mode_q == 2'd1);
   assign tri_mode = (mode_q == 2'd2);

   // A triangle sitting on its target reverses on the same dwell that takes the next step.
   assign flip   = at_tgt && tri_mode;
   assign dir_up = flip ? (state != RUN_UP) : (state == RUN_UP);
   assign ret    = flip ? !returning : returning;
   assign tgt    = ret ? start_q : end_q;

   assign sum  = {1'b0, ramp_out} + {1'b0, step_q};
   assign diff = {1'b0, ramp_out} - {1'b0, step_q};

   always_comb begin
      stepped = '0;
      if (dir_up)
         stepped = (sum[WIDTH] || (sum[WIDTH-1:0] > tgt)) ? tgt : sum[WIDTH-1:0];
      else
         stepped = (diff[WIDTH] || (diff[WIDTH-1:0] < tgt)) ? tgt : diff[WIDTH-1:0];
   end

   always_comb begin
      state_n     = state;
      ramp_n      = ramp_out;
      cnt_n       = cnt;
      start_n     = start_q;
      end_n       = end_q;
      step_n      = step_q;
      pulse_n     = pulse_q;
      mode_n      = mode_q;
      returning_n = returning;
      at_tgt_n    = at_tgt;
      strobe_n    = 1'b0;
      done_n      = 1'b0;

      if (param_load) begin
         start_n     = cfg_start;
         end_n       = cfg_end;
         step_n      = cfg_step;
         pulse_n     = (cfg_pulse == '0) ? CNT_WIDTH'(1) : cfg_pulse;
         mode_n      = cfg_mode;
         ramp_n      = cfg_start;
         cnt_n       = '0;
         state_n     = (cfg_start <= cfg_end) ? RUN_UP : RUN_DN;
         returning_n = 1'b0;
         at_tgt_n    = 1'b0;
         strobe_n    = 1'b1;
      end else if (en && (state == RUN_UP || state == RUN_DN)) begin
         if (cnt == pulse_q - CNT_WIDTH'(1)) begin
            cnt_n    = '0;
            strobe_n = 1'b1;
            if (at_tgt && saw_mode) begin
               ramp_n   = start_q;
               at_tgt_n = 1'b0;
            end else begin
               ramp_n      = stepped;
               returning_n = ret;
               state_n     = dir_up ? RUN_UP : RUN_DN;
               at_tgt_n    = (stepped == tgt);
               // Only the outbound leg toward end reports completion.
               if ((stepped == tgt) && !ret) begin
                  done_n = 1'b1;
                  if (!saw_mode && !tri_mode)
                     state_n = DONE;
               end
            end
         end else begin
            cnt_n = cnt + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge dac_clk) begin
      if (!rstn) begin
         state       <= IDLE;
         ramp_out    <= '0;
         cnt         <= '0;
         start_q     <= '0;
         end_q       <= '0;
         step_q      <= '0;
         pulse_q     <= '0;
         mode_q      <= '0;
         returning   <= 1'b0;
         at_tgt      <= 1'b0;
         step_strobe <= 1'b0;
         sweep_done  <= 1'b0;
      end else begin
         state       <= state_n;
         ramp_out    <= ramp_n;
         cnt         <= cnt_n;
         start_q     <= start_n;
         end_q       <= end_n;
         step_q      <= step_n;
         pulse_q     <= pulse_n;
         mode_q      <= mode_n;
         returning   <= returning_n;
         at_tgt      <= at_tgt_n;
         step_strobe <= strobe_n;
         sweep_done  <= done_n;
      end
   end

   assign active = (state == RUN_UP) || (state == RUN_DN);

endmodule
